// File: rtl/cic_decim_prog.sv
`default_nettype none
//==============================================================================
// Module   : cic_decim_prog
// Purpose  : Multi-lane CIC decimator with run-time factor, full-precision
//            accumulators and rounded, saturated output scaling.
// Revision : 1.0
//==============================================================================
module cic_decim_prog #(
    parameter  int IN_WIDTH   = 16,
    parameter  int OUT_WIDTH  = 16,
    parameter  int CHANNELS   = 2,
    parameter  int STAGES     = 5,
    parameter  int DELAY      = 1,
    parameter  int MAX_FACTOR = 512,
    localparam int ACC_WIDTH  = IN_WIDTH + STAGES * $clog2(MAX_FACTOR * DELAY),
    localparam int SH_WIDTH   = $clog2(ACC_WIDTH),
    localparam int FW         = $clog2(MAX_FACTOR + 1)
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic                          i_clear,
    input  logic [FW-1:0]                 i_factor,
    input  logic [SH_WIDTH-1:0]           i_shift,
    input  logic [CHANNELS*IN_WIDTH-1:0]  i_data,
    input  logic                          i_valid,
    output logic [CHANNELS*OUT_WIDTH-1:0] o_data,
    output logic                          o_valid,
    output logic [CHANNELS-1:0]           o_sat
);

    localparam logic signed [ACC_WIDTH:0] OUT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] OUT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic [STAGES-1:0] int_vld_q;
    logic [STAGES-1:0] comb_vld_q;
    logic [STAGES-1:0] comb_in_vld;
    logic              dec_vld_q;
    logic              out_vld_q;
    logic              load_q;
    logic [FW-1:0]     cnt_q;
    logic [FW-1:0]     cnt_d;
    logic [FW-1:0]     factor_q;
    logic [FW-1:0]     factor_d;
    logic [FW-1:0]     factor_clamped;
    logic              wrap;

    always_comb begin
        factor_clamped = i_factor;
        if (i_factor == '0) begin
            factor_clamped = FW'(1);
        end else if (i_factor > FW'(MAX_FACTOR)) begin
            factor_clamped = FW'(MAX_FACTOR);
        end
    end

    assign wrap = int_vld_q[STAGES-1] && (cnt_q >= factor_q - FW'(1));

    // The factor only reloads at a period boundary; load_q picks it up on the
    // first edge after reset because a reset value cannot come from a port.
    always_comb begin
        cnt_d    = cnt_q;
        factor_d = factor_q;
        if (load_q) begin
            factor_d = factor_clamped;
        end
        if (int_vld_q[STAGES-1]) begin
            if (wrap) begin
                cnt_d    = '0;
                factor_d = factor_clamped;
            end else begin
                cnt_d = cnt_q + FW'(1);
            end
        end
    end

    always_comb begin
        comb_in_vld[0] = dec_vld_q;
        for (int s = 1; s < STAGES; s++) begin
            comb_in_vld[s] = comb_vld_q[s-1];
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            int_vld_q  <= '0;
            comb_vld_q <= '0;
            dec_vld_q  <= 1'b0;
            out_vld_q  <= 1'b0;
            cnt_q      <= '0;
            factor_q   <= FW'(1);
            load_q     <= 1'b1;
        end else if (i_clear) begin
            int_vld_q  <= '0;
            comb_vld_q <= '0;
            dec_vld_q  <= 1'b0;
            out_vld_q  <= 1'b0;
            cnt_q      <= '0;
            factor_q   <= factor_clamped;
            load_q     <= 1'b0;
        end else begin
            int_vld_q[0] <= i_valid;
            for (int s = 1; s < STAGES; s++) begin
                int_vld_q[s] <= int_vld_q[s-1];
            end
            dec_vld_q     <= wrap;
            comb_vld_q[0] <= dec_vld_q;
            for (int s = 1; s < STAGES; s++) begin
                comb_vld_q[s] <= comb_vld_q[s-1];
            end
            out_vld_q <= comb_vld_q[STAGES-1];
            cnt_q     <= cnt_d;
            factor_q  <= factor_d;
            load_q    <= 1'b0;
        end
    end

    assign o_valid = out_vld_q;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_lane
        logic signed [ACC_WIDTH-1:0] x_ext;
        logic signed [ACC_WIDTH-1:0] integ_q [STAGES];
        logic signed [ACC_WIDTH-1:0] dec_q;
        logic signed [ACC_WIDTH-1:0] comb_in [STAGES];
        logic signed [ACC_WIDTH-1:0] comb_q  [STAGES];
        logic signed [ACC_WIDTH-1:0] dly_q   [STAGES][DELAY];
        logic signed [ACC_WIDTH:0]   sh_ext;
        logic signed [ACC_WIDTH:0]   rnd;
        logic [OUT_WIDTH-1:0]        sat_val;
        logic                        sat_flag;
        logic [OUT_WIDTH-1:0]        out_q;
        logic                        sat_q;

        assign x_ext = {{(ACC_WIDTH-IN_WIDTH){i_data[ch*IN_WIDTH+IN_WIDTH-1]}},
                        i_data[ch*IN_WIDTH +: IN_WIDTH]};

        always_comb begin
            comb_in[0] = dec_q;
            for (int s = 1; s < STAGES; s++) begin
                comb_in[s] = comb_q[s-1];
            end
        end

        // A zero appended below the LSB lets the shift deliver the round bit
        // in bit 0 for any shift amount, including zero and beyond the width.
        always_comb begin
            sh_ext   = $signed({comb_q[STAGES-1], 1'b0}) >>> i_shift;
            rnd      = {sh_ext[ACC_WIDTH], sh_ext[ACC_WIDTH:1]}
                     + (ACC_WIDTH+1)'(sh_ext[0]);
            sat_val  = rnd[OUT_WIDTH-1:0];
            sat_flag = 1'b0;
            if (rnd > OUT_MAX) begin
                sat_val  = OUT_MAX[OUT_WIDTH-1:0];
                sat_flag = 1'b1;
            end else if (rnd < OUT_MIN) begin
                sat_val  = OUT_MIN[OUT_WIDTH-1:0];
                sat_flag = 1'b1;
            end
        end

        always_ff @(posedge i_clock or posedge i_reset) begin
            if (i_reset) begin
                for (int s = 0; s < STAGES; s++) begin
                    integ_q[s] <= '0;
                    comb_q[s]  <= '0;
                    for (int d = 0; d < DELAY; d++) begin
                        dly_q[s][d] <= '0;
                    end
                end
                dec_q <= '0;
                out_q <= '0;
                sat_q <= 1'b0;
            end else if (i_clear) begin
                for (int s = 0; s < STAGES; s++) begin
                    integ_q[s] <= '0;
                    comb_q[s]  <= '0;
                    for (int d = 0; d < DELAY; d++) begin
                        dly_q[s][d] <= '0;
                    end
                end
                dec_q <= '0;
                out_q <= '0;
                sat_q <= 1'b0;
            end else begin
                if (i_valid) begin
                    integ_q[0] <= integ_q[0] + x_ext;
                end
                for (int s = 1; s < STAGES; s++) begin
                    if (int_vld_q[s-1]) begin
                        integ_q[s] <= integ_q[s] + integ_q[s-1];
                    end
                end
                if (wrap) begin
                    dec_q <= integ_q[STAGES-1];
                end
                for (int s = 0; s < STAGES; s++) begin
                    if (comb_in_vld[s]) begin
                        comb_q[s]   <= comb_in[s] - dly_q[s][DELAY-1];
                        dly_q[s][0] <= comb_in[s];
                        for (int d = 1; d < DELAY; d++) begin
                            dly_q[s][d] <= dly_q[s][d-1];
                        end
                    end
                end
                if (comb_vld_q[STAGES-1]) begin
                    out_q <= sat_val;
                    sat_q <= sat_flag;
                end
            end
        end

        assign o_data[ch*OUT_WIDTH +: OUT_WIDTH] = out_q;
        assign o_sat[ch]                         = sat_q;
    end

endmodule
`default_nettype wire
